mem_stage_unit: RTL and testbench

- Memory-stage access controller; sits between the EX/MEM pipeline register and the 2K x 16 data memory.
- Decodes the memory operation and drives the memory's address, write data, read, write and CS.
- Owns the stack pointer. Splits 32-bit PC push/pop (CALL/RET) into two 16-bit accesses and stalls the pipeline for one cycle while doing so.

---
 rtl/mem_stage_unit.sv | 140 ++++++++++++++
 tb/tb_mem_stage_unit.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_unit.sv
// rtl/mem_stage_unit.sv - memory-stage access controller with stack pointer and split CALL/RET
// Drives the 2K x 16 data memory; 32-bit PC push/pop is split into two 16-bit accesses.
module mem_stage_unit #(
  parameter logic [10:0] SP_RESET = 11'h7FF,
  parameter int          OP_W     = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [OP_W-1:0] op,
  input  logic [31:0]     alu_addr,
  input  logic [15:0]     store_data,
  input  logic [31:0]     pc_in,
  input  logic [15:0]     mem_read_data,
  output logic [31:0]     mem_address,
  output logic [15:0]     mem_write_data,
  output logic            mem_read,
  output logic            mem_write,
  output logic            mem_cs,
  output logic [15:0]     load_data,
  output logic [31:0]     pc_out,
  output logic            pc_valid,
  output logic            stall,
  output logic [10:0]     sp_out
);

  localparam logic [OP_W-1:0] OP_LOAD  = OP_W'(1);
  localparam logic [OP_W-1:0] OP_STORE = OP_W'(2);
  localparam logic [OP_W-1:0] OP_PUSH  = OP_W'(3);
  localparam logic [OP_W-1:0] OP_POP   = OP_W'(4);
  localparam logic [OP_W-1:0] OP_CALL  = OP_W'(5);
  localparam logic [OP_W-1:0] OP_RET   = OP_W'(6);

  typedef enum logic {FIRST, SECOND} state_t;

  state_t      state_q, state_d;
  logic [10:0] sp_q, sp_d;
  logic [15:0] pc_lo_q, pc_lo_d;
  logic [10:0] sp_inc, sp_dec;

  assign sp_inc = sp_q + 11'd1;
  assign sp_dec = sp_q - 11'd1;
  assign sp_out = sp_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= FIRST;
      sp_q    <= SP_RESET;
      pc_lo_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      sp_q    <= sp_d;
      pc_lo_q <= pc_lo_d;
    end
  end

  always_comb begin
    state_d        = FIRST;
    sp_d           = sp_q;
    pc_lo_d        = pc_lo_q;
    mem_address    = 32'h0;
    mem_write_data = 16'h0;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_cs         = 1'b0;
    load_data      = 16'h0;
    pc_out         = 32'h0;
    pc_valid       = 1'b0;
    stall          = 1'b0;
    // A non-CALL/RET op seen in SECOND is simply executed as in FIRST.
    case (op)
      OP_LOAD: begin
        mem_cs      = 1'b1;
        mem_read    = 1'b1;
        mem_address = alu_addr;
        load_data   = mem_read_data;
      end
      OP_STORE: begin
        mem_cs         = 1'b1;
        mem_write      = 1'b1;
        mem_address    = alu_addr;
        mem_write_data = store_data;
      end
      OP_PUSH: begin
        mem_cs         = 1'b1;
        mem_write      = 1'b1;
        mem_address    = {21'h0, sp_q};
        mem_write_data = store_data;
        sp_d           = sp_dec;
      end
      OP_POP: begin
        mem_cs      = 1'b1;
        mem_read    = 1'b1;
        mem_address = {21'h0, sp_inc};
        load_data   = mem_read_data;
        sp_d        = sp_inc;
      end
      OP_CALL: begin
        mem_cs      = 1'b1;
        mem_write   = 1'b1;
        mem_address = {21'h0, sp_q};
        sp_d        = sp_dec;
        if (state_q == FIRST) begin
          mem_write_data = pc_in[31:16];
          stall          = 1'b1;
          state_d        = SECOND;
        end else begin
          mem_write_data = pc_in[15:0];
        end
      end
      OP_RET: begin
        mem_cs      = 1'b1;
        mem_read    = 1'b1;
        mem_address = {21'h0, sp_inc};
        sp_d        = sp_inc;
        if (state_q == FIRST) begin
          stall   = 1'b1;
          pc_lo_d = mem_read_data;
          state_d = SECOND;
        end else begin
          pc_out   = {mem_read_data, pc_lo_q};
          pc_valid = 1'b1;
        end
      end
      default: ;
    endcase
    // Outputs are quiet while reset is held, even mid CALL/RET.
    if (!rst) begin
      mem_address    = 32'h0;
      mem_write_data = 16'h0;
      mem_read       = 1'b0;
      mem_write      = 1'b0;
      mem_cs         = 1'b0;
      load_data      = 16'h0;
      pc_out         = 32'h0;
      pc_valid       = 1'b0;
      stall          = 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_stage_unit.sv
// tb/tb_mem_stage_unit.sv - self-checking bench for mem_stage_unit
// Table-driven vectors through a scoreboard queue, plus wrap-around and reset-abort sequences.
module tb_mem_stage_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  op;
  logic [31:0] alu_addr;
  logic [15:0] store_data;
  logic [31:0] pc_in;
  logic [15:0] mem_read_data;
  logic [31:0] mem_address;
  logic [15:0] mem_write_data;
  logic        mem_read, mem_write, mem_cs;
  logic [15:0] load_data;
  logic [31:0] pc_out;
  logic        pc_valid, stall;
  logic [10:0] sp_out;

  int tests = 0;
  int fails = 0;

  logic [15:0] mem [2048];

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_write) mem[mem_address[10:0]] <= mem_write_data;
  assign mem_read_data = mem[mem_address[10:0]];

  mem_stage_unit #(.SP_RESET(11'h7FF), .OP_W(3)) dut (
    .clk(clk), .rst(rst), .op(op), .alu_addr(alu_addr), .store_data(store_data),
    .pc_in(pc_in), .mem_read_data(mem_read_data), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .mem_read(mem_read), .mem_write(mem_write),
    .mem_cs(mem_cs), .load_data(load_data), .pc_out(pc_out), .pc_valid(pc_valid),
    .stall(stall), .sp_out(sp_out)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] addr_in;
    logic [15:0] sdata;
    logic [31:0] pc;
    logic [31:0] e_addr;
    logic        e_wr;
    logic        e_rd;
    logic [15:0] e_wdata;
    logic [15:0] e_load;
    logic        e_stall;
    logic        e_pcv;
    logic [31:0] e_pc;
    logic [10:0] e_sp;
  } vec_t;

  vec_t vecs [19];
  vec_t sb [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] o, input logic [31:0] a, input logic [15:0] s,
                              input logic [31:0] p, input logic [31:0] ea, input logic ew,
                              input logic er, input logic [15:0] ed, input logic [15:0] el,
                              input logic es, input logic ev, input logic [31:0] ep,
                              input logic [10:0] esp);
    vec_t v;
    v.op = o; v.addr_in = a; v.sdata = s; v.pc = p; v.e_addr = ea; v.e_wr = ew; v.e_rd = er;
    v.e_wdata = ed; v.e_load = el; v.e_stall = es; v.e_pcv = ev; v.e_pc = ep; v.e_sp = esp;
    return v;
  endfunction

  task automatic drive(input logic [2:0] o, input logic [31:0] a, input logic [15:0] s,
                       input logic [31:0] p);
    op = o; alu_addr = a; store_data = s; pc_in = p;
  endtask

  initial begin
    vec_t e;
    for (int i = 0; i < 2048; i++) mem[i] = 16'h0;
    //            op  alu_addr      sdata    pc_in         addr         wr rd wdata    load     st pv pc_out        sp
    vecs[0]  = mk(0, 32'h0,        16'h0,   32'h0,        32'h0,       0, 0, 16'h0,   16'h0,   0, 0, 32'h0,        11'h7FF);
    vecs[1]  = mk(2, 32'h10,       16'hBEEF,32'h0,        32'h10,      1, 0, 16'hBEEF,16'h0,   0, 0, 32'h0,        11'h7FF);
    vecs[2]  = mk(1, 32'h10,       16'h0,   32'h0,        32'h10,      0, 1, 16'h0,   16'hBEEF,0, 0, 32'h0,        11'h7FF);
    vecs[3]  = mk(3, 32'h0,        16'h1234,32'h0,        32'h7FF,     1, 0, 16'h1234,16'h0,   0, 0, 32'h0,        11'h7FE);
    vecs[4]  = mk(3, 32'h0,        16'h5678,32'h0,        32'h7FE,     1, 0, 16'h5678,16'h0,   0, 0, 32'h0,        11'h7FD);
    vecs[5]  = mk(4, 32'h0,        16'h0,   32'h0,        32'h7FE,     0, 1, 16'h0,   16'h5678,0, 0, 32'h0,        11'h7FE);
    vecs[6]  = mk(4, 32'h0,        16'h0,   32'h0,        32'h7FF,     0, 1, 16'h0,   16'h1234,0, 0, 32'h0,        11'h7FF);
    vecs[7]  = mk(5, 32'h0,        16'h0,   32'hCAFE0042, 32'h7FF,     1, 0, 16'hCAFE,16'h0,   1, 0, 32'h0,        11'h7FE);
    vecs[8]  = mk(5, 32'h0,        16'h0,   32'hCAFE0042, 32'h7FE,     1, 0, 16'h0042,16'h0,   0, 0, 32'h0,        11'h7FD);
    vecs[9]  = mk(6, 32'h0,        16'h0,   32'h0,        32'h7FE,     0, 1, 16'h0,   16'h0,   1, 0, 32'h0,        11'h7FE);
    vecs[10] = mk(6, 32'h0,        16'h0,   32'h0,        32'h7FF,     0, 1, 16'h0,   16'h0,   0, 1, 32'hCAFE0042, 11'h7FF);
    vecs[11] = mk(7, 32'h55,       16'h77,  32'h0,        32'h0,       0, 0, 16'h0,   16'h0,   0, 0, 32'h0,        11'h7FF);
    vecs[12] = mk(5, 32'h0,        16'h0,   32'h12345678, 32'h7FF,     1, 0, 16'h1234,16'h0,   1, 0, 32'h0,        11'h7FE);
    vecs[13] = mk(1, 32'h10,       16'h0,   32'h0,        32'h10,      0, 1, 16'h0,   16'hBEEF,0, 0, 32'h0,        11'h7FE);
    vecs[14] = mk(5, 32'h0,        16'h0,   32'h00000077, 32'h7FE,     1, 0, 16'h0000,16'h0,   1, 0, 32'h0,        11'h7FD);
    vecs[15] = mk(5, 32'h0,        16'h0,   32'h00000077, 32'h7FD,     1, 0, 16'h0077,16'h0,   0, 0, 32'h0,        11'h7FC);
    vecs[16] = mk(6, 32'h0,        16'h0,   32'h0,        32'h7FD,     0, 1, 16'h0,   16'h0,   1, 0, 32'h0,        11'h7FD);
    vecs[17] = mk(6, 32'h0,        16'h0,   32'h0,        32'h7FE,     0, 1, 16'h0,   16'h0,   0, 1, 32'h00000077, 11'h7FE);
    vecs[18] = mk(4, 32'h0,        16'h0,   32'h0,        32'h7FF,     0, 1, 16'h0,   16'h1234,0, 0, 32'h0,        11'h7FF);

    rst = 1'b0;
    drive(0, 32'h0, 16'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_sp", 32'(sp_out), 32'h7FF);
    chk("reset_ctrl", {29'h0, mem_cs, mem_read, mem_write}, 32'h0);
    chk("reset_stall", 32'(stall), 32'h0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      drive(vecs[i].op, vecs[i].addr_in, vecs[i].sdata, vecs[i].pc);
      sb.push_back(vecs[i]);
      #2;
      e = sb.pop_front();
      chk($sformatf("v%0d_addr", i), mem_address, e.e_addr);
      chk($sformatf("v%0d_ctl", i), {29'h0, mem_cs, mem_read, mem_write},
          {29'h0, (e.op >= 3'd1 && e.op <= 3'd6), e.e_rd, e.e_wr});
      chk($sformatf("v%0d_wdata", i), 32'(mem_write_data), 32'(e.e_wdata));
      chk($sformatf("v%0d_load", i), 32'(load_data), 32'(e.e_load));
      chk($sformatf("v%0d_stall", i), 32'(stall), 32'(e.e_stall));
      chk($sformatf("v%0d_pcv", i), 32'(pc_valid), 32'(e.e_pcv));
      chk($sformatf("v%0d_pc", i), pc_out, e.e_pc);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_sp", i), 32'(sp_out), 32'(e.e_sp));
      if (i == 8) begin
        chk("call_mem_hi", 32'(mem[11'h7FF]), 32'hCAFE);
        chk("call_mem_lo", 32'(mem[11'h7FE]), 32'h0042);
      end
    end

    for (int i = 0; i < 2047; i++) begin
      @(negedge clk);
      drive(3, 32'h0, 16'(i), 32'h0);
    end
    @(posedge clk);
    #1;
    chk("wrap_sp_zero", 32'(sp_out), 32'h0);
    @(negedge clk);
    drive(3, 32'h0, 16'hAAAA, 32'h0);
    #2;
    chk("wrap_push_addr", mem_address, 32'h0);
    @(posedge clk);
    #1;
    chk("wrap_mem0", 32'(mem[0]), 32'hAAAA);
    chk("wrap_sp_top", 32'(sp_out), 32'h7FF);
    @(negedge clk);
    drive(4, 32'h0, 16'h0, 32'h0);
    #2;
    chk("wrap_pop_addr", mem_address, 32'h0);
    chk("wrap_pop_data", 32'(load_data), 32'hAAAA);
    @(posedge clk);
    #1;
    chk("wrap_pop_sp", 32'(sp_out), 32'h0);

    @(negedge clk);
    drive(5, 32'h0, 16'h0, 32'hDEAD0001);
    #2;
    chk("abort_pre_stall", 32'(stall), 32'h1);
    rst = 1'b0;
    #1;
    chk("abort_stall", 32'(stall), 32'h0);
    chk("abort_write", 32'(mem_write), 32'h0);
    chk("abort_sp", 32'(sp_out), 32'h7FF);
    @(posedge clk);
    #1;
    chk("abort_mem0", 32'(mem[0]), 32'hAAAA);
    @(negedge clk);
    rst = 1'b1;
    drive(0, 32'h0, 16'h0, 32'h0);
    @(negedge clk);
    drive(5, 32'h0, 16'h0, 32'hBEEF0002);
    #2;
    chk("post_call_stall", 32'(stall), 32'h1);
    chk("post_call_wdata", 32'(mem_write_data), 32'hBEEF);
    chk("post_call_addr", mem_address, 32'h7FF);
    @(negedge clk);
    #2;
    chk("post_call_b_stall", 32'(stall), 32'h0);
    chk("post_call_b_wdata", 32'(mem_write_data), 32'h0002);
    @(negedge clk);
    drive(0, 32'h0, 16'h0, 32'h0);
    @(posedge clk);
    #1;
    chk("post_call_sp", 32'(sp_out), 32'h7FD);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
